// File: rtl/ce_register_if.sv
// ce_register_if -- data/enable bundle for the ce_register storage element.
//
// Signals:
//   IN   [WIDTH-1:0]  data to be loaded
//   CE                clock enable, active-high load strobe
//   OUT  [WIDTH-1:0]  stored value returned by the register
//
// Modports:
//   master  drives IN/CE, observes OUT (the datapath controller)
//   slave   observes IN/CE, drives OUT (the register itself)
interface ce_register_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] IN;
    logic             CE;
    logic [WIDTH-1:0] OUT;

    modport master (
        output IN,
        output CE,
        input  OUT
    );

    modport slave (
        input  IN,
        input  CE,
        output OUT
    );
endinterface

// File: rtl/ce_register.sv
// ce_register -- width-parameterised storage register with clock enable.
// Used as the general-purpose and accumulator register in the datapath.
//
// Parameters:
//   WIDTH        data width in bits (>= 1); must match the interface WIDTH
//   RESET_VALUE  value forced onto OUT while RST is low (WIDTH bits)
//
// Ports:
//   CLK  system clock, rising-edge active
//   RST  asynchronous reset, active-low
//   bus  slave side of ce_register_if: IN/CE in, OUT out (straight from flops)
module ce_register #(
    parameter int unsigned         WIDTH       = 4,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input logic            CLK,
    input logic            RST,
    ce_register_if.slave   bus
);
    // Bit-for-bit copy on enabled edges; reset dominates any load.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.OUT <= RESET_VALUE;
        end else if (bus.CE) begin
            bus.OUT <= bus.IN;
        end
    end
endmodule

// File: tb/tb_ce_register.sv
// tb_ce_register -- directed self-checking bench for ce_register.
// Two instances: default (WIDTH=4, reset 0) and WIDTH=8 with reset 8'hA5.
module tb_ce_register;
    logic CLK;
    logic RST;

    ce_register_if #(.WIDTH(4)) bus4 ();
    ce_register_if #(.WIDTH(8)) bus8 ();

    ce_register #(
        .WIDTH       (4)
    ) dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4.slave)
    );

    ce_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus8.slave)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Record what the register must show at the next comparison point.
    task automatic sb_push(input string tag, input logic [7:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the observed output.
    task automatic sb_check(input logic [7:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST      = 1'b1;
        bus4.CE  = 1'b0;
        bus4.IN  = 4'h0;
        bus8.CE  = 1'b0;
        bus8.IN  = 8'h00;

        // 1. Power-up reset, asserted before any clock edge.
        #1 RST = 1'b0;
        #1;
        sb_push("reset_async_w4", 8'h00);
        sb_check({4'h0, bus4.OUT});
        sb_push("reset_async_w8", 8'hA5);
        sb_check(bus8.OUT);
        step();
        sb_push("reset_hold_w4", 8'h00);
        sb_check({4'h0, bus4.OUT});
        RST = 1'b1;
        step();
        sb_push("release_noload", 8'h00);
        sb_check({4'h0, bus4.OUT});

        // 2. Hold with CE low while IN changes mid-cycle.
        #3 bus4.IN = 4'h5;
        step();
        sb_push("hold_ce0_a", 8'h00);
        sb_check({4'h0, bus4.OUT});
        step();
        sb_push("hold_ce0_b", 8'h00);
        sb_check({4'h0, bus4.OUT});

        // 3. Load 5, then keep reloading the same value.
        bus4.CE = 1'b1;
        #2;
        sb_push("pre_edge_no_load", 8'h00);
        sb_check({4'h0, bus4.OUT});
        step();
        sb_push("load_5", 8'h05);
        sb_check({4'h0, bus4.OUT});
        step();
        sb_push("reload_5", 8'h05);
        sb_check({4'h0, bus4.OUT});

        // 4. Hold after load, then load 9.
        bus4.CE = 1'b0;
        bus4.IN = 4'h9;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            sb_push("hold_after_load", 8'h05);
            sb_check({4'h0, bus4.OUT});
        end
        bus4.CE = 1'b1;
        step();
        sb_push("load_9", 8'h09);
        sb_check({4'h0, bus4.OUT});

        // 5. Async reset between edges with CE high; reset dominates load.
        bus8.CE = 1'b1;
        bus8.IN = 8'h3C;
        step();
        sb_push("w8_load_3c", 8'h3C);
        sb_check(bus8.OUT);
        #2 RST = 1'b0;
        #1;
        sb_push("midcycle_reset_w4", 8'h00);
        sb_check({4'h0, bus4.OUT});
        sb_push("midcycle_reset_w8", 8'hA5);
        sb_check(bus8.OUT);
        step();
        sb_push("reset_dominates_a", 8'h00);
        sb_check({4'h0, bus4.OUT});
        step();
        sb_push("reset_dominates_b", 8'h00);
        sb_check({4'h0, bus4.OUT});
        RST = 1'b1;
        #2;
        sb_push("release_before_edge", 8'h00);
        sb_check({4'h0, bus4.OUT});
        step();
        sb_push("reload_9_after_release", 8'h09);
        sb_check({4'h0, bus4.OUT});

        // 6. Streaming boundary values with CE held high.
        bus4.IN = 4'hF;
        step();
        sb_push("stream_f", 8'h0F);
        sb_check({4'h0, bus4.OUT});
        bus4.IN = 4'h0;
        step();
        sb_push("stream_0", 8'h00);
        sb_check({4'h0, bus4.OUT});
        bus4.IN = 4'hA;
        step();
        sb_push("stream_a", 8'h0A);
        sb_check({4'h0, bus4.OUT});
        bus4.IN = 4'h5;
        step();
        sb_push("stream_5", 8'h05);
        sb_check({4'h0, bus4.OUT});

        // Wide instance: all-ones load and hold.
        bus8.IN = 8'hFF;
        step();
        sb_push("w8_load_ff", 8'hFF);
        sb_check(bus8.OUT);
        bus8.CE = 1'b0;
        bus8.IN = 8'h00;
        step();
        sb_push("w8_hold_ff", 8'hFF);
        sb_check(bus8.OUT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ce_register.md
Name: ce_register

Overview:
- Width-parameterised storage register with a clock-enable. The default width is 4 bits.
- Serves as the general-purpose and accumulator register building block in the microprocessor datapath.
- Captures IN on a rising CLK edge when CE is high, and holds its value otherwise.
- An asynchronous active-low reset forces the stored value to a fixed reset constant.

Parameters:
- WIDTH, default 4: data width of IN and OUT, in bits. Legal range is 1 or more.
- RESET_VALUE, default 0: value loaded into OUT while reset is asserted. It is truncated to WIDTH bits.

Ports:
- CLK  input  1  Single system clock. All state changes on its rising edge, except reset.
- RST  input  1  Reset, asynchronous, active-low. 0 means reset asserted.
- IN  input  WIDTH  Data to be loaded.
- CE  input  1  Clock enable, active-high load strobe.
- OUT  output  WIDTH  Current stored value, driven directly from the flops with no combinational path from IN.

Behaviour:
- One clock domain. Reset is asynchronous and active-low. These two points are fixed.
- Reset assertion:
  - On the falling edge of RST, OUT becomes RESET_VALUE immediately, with no clock needed.
  - This holds regardless of CLK, CE and IN.
- While RST=0:
  - OUT stays at RESET_VALUE.
  - CE=1 and clock edges have no effect, so reset dominates load.
- Reset release (RST 0 to 1):
  - OUT keeps RESET_VALUE.
  - The first possible load happens at the first rising CLK edge after release where CE=1.
  - RST and CE are both synchronous to CLK at the system level, so no special deassertion-edge handling is required.
- Load:
  - At a rising CLK edge with RST=1 and CE=1, OUT takes the value IN had just before the edge.
  - Latency is one edge: the new value is visible after the edge and stays stable for the whole following cycle.
- Hold: at a rising CLK edge with RST=1 and CE=0, OUT is unchanged.
- IN changes between edges never affect OUT. The register is edge-triggered, not a latch.
- CE held high:
  - OUT follows IN with a one-cycle delay, loading every edge.
  - Reloading an identical value causes no glitch.
- Width rule: exact bit-for-bit copy with no arithmetic, sign handling or masking. Every bit of IN maps to the same bit of OUT.
- Before the first reset, OUT is undefined (X in simulation). The system must assert RST at power-up.
- X/Z on CE while RST=1 may propagate X to OUT. No X-suppression is required.
- Synthesis result: WIDTH D-flops with async clear or preset chosen per RESET_VALUE bit, plus a 2:1 enable mux or clock-enable flop primitive. No clock gating.

Test Plan:
1. Power-up: RST=0, CE=0, IN=0, with CLK toggling every 5 ns. Then release RST=1 -> OUT=0 through release, with no load.
2. Hold with CE low: RST=1, CE=0, IN changes 0 to 5 mid-cycle -> OUT stays 0 across at least two rising edges.
3. Load: IN=5, raise CE=1 -> OUT=5 right after the next rising edge, and stays 5 while CE=1 and IN=5.
4. Hold after load: drop CE=0, set IN=9 -> OUT stays 5 over several edges. Then raise CE=1 -> OUT=9 after the next rising edge.
5. Async reset mid-operation: with OUT=9 and CE=1, assert RST=0 between clock edges -> OUT=0 immediately, not at the next edge. OUT stays 0 through edges while RST=0 even with CE=1 and IN=9. Release RST -> OUT=9 one edge later.
6. Streaming and boundary values: CE=1, IN sequence F, 0, A, 5 on consecutive edges -> OUT shows the same sequence delayed by one cycle. Also instantiate with WIDTH=8, RESET_VALUE=8'hA5 -> reset gives A5, and a load of FF gives FF.
